// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory response block: access sizes and FSM states.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  function automatic logic [3:0] size_bytes(input mem_size_t sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the low-order bytes of a little-endian load window and sign/zero extends them.
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [63:0] raw,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [63:0] data
);

  always_comb begin
    data = raw;
    case (size)
      SZ_B:    data = is_unsigned ? {56'b0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
      SZ_H:    data = is_unsigned ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      SZ_W:    data = is_unsigned ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// Byte-addressable data memory with fixed response latency and one outstanding request.
// state | meaning
// IDLE  | ready for a request
// WAIT  | latency counter running down
// RESP  | response held until rsp_ready
module data_mem_resp
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [7:0] mem [0:DEPTH_BYTES-1];

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  mem_size_t   size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] wdata_q, wdata_d;

  // With LATENCY=1 the response is produced on the accept edge, so use the live request then.
  logic        cur_we, cur_uns;
  logic [63:0] cur_addr, cur_wdata;
  mem_size_t   cur_size;
  always_comb begin
    cur_we    = (state_q == IDLE) ? req_we                  : we_q;
    cur_addr  = (state_q == IDLE) ? req_addr                : addr_q;
    cur_size  = (state_q == IDLE) ? mem_size_t'(req_size)   : size_q;
    cur_uns   = (state_q == IDLE) ? req_unsigned            : uns_q;
    cur_wdata = (state_q == IDLE) ? req_wdata               : wdata_q;
  end

  logic [3:0]  nbytes, nb_m1;
  logic        err_w;
  logic [63:0] raw_win, ext_data;
  always_comb begin
    nbytes = size_bytes(cur_size);
    nb_m1  = nbytes - 4'd1;
    err_w  = (|(cur_addr[3:0] & nb_m1)) ||
             (({1'b0, cur_addr} + {61'b0, nbytes}) > 65'(DEPTH_BYTES));
    raw_win = '0;
    for (int i = 0; i < 8; i++) begin
      raw_win[8*i +: 8] = mem[cur_addr[AW-1:0] + AW'(i)];
    end
  end

  load_extend u_load_extend (
    .raw         (raw_win),
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .data        (ext_data)
  );

  logic do_resp;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    do_resp     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          addr_d      = req_addr;
          size_d      = mem_size_t'(req_size);
          uns_d       = req_unsigned;
          wdata_d     = req_wdata;
          cnt_d       = LAT_M1;
          req_ready_d = 1'b0;
          if (LATENCY == 1) begin
            state_d = RESP;
            do_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          do_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_w;
      rsp_rdata_d = (err_w || cur_we) ? 64'd0 : ext_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
    end
  end

  // Storage survives reset; the rst_n gate keeps a request seen during reset from writing.
  always_ff @(posedge clk) begin
    if (do_resp && cur_we && !err_w && rst_n) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(nbytes)) mem[cur_addr[AW-1:0] + AW'(i)] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomized scoreboard bench for data_mem_resp against a byte-array reference model.
module tb_data_mem_resp;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          drive_cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  logic [7:0]  model_mem [DEPTH];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: size rules, range/alignment and extension by plain arithmetic on a byte array.
  function automatic void model_req(input logic we, input logic [63:0] addr, input logic [1:0] size,
                                    input logic uns, input logic [63:0] wdata,
                                    output logic [63:0] rdata, output logic err);
    int nb;
    nb    = 1 << size;
    rdata = 64'd0;
    err   = ((addr % nb) != 0) || (({1'b0, addr} + 65'(nb)) > 65'(DEPTH));
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) model_mem[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) rdata += {56'b0, model_mem[int'(addr) + i]} << (8 * i);
        if (!uns && nb < 8 && rdata >= (64'd1 << (8 * nb - 1))) rdata = rdata - (64'd1 << (8 * nb));
      end
    end
  endfunction

  task automatic issue(input logic we, input logic [63:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata, input bit track);
    int n;
    logic [63:0] r;
    logic ee;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_wait", req_ready, 1);
      return;
    end
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    if (track) begin
      model_req(we, addr, size, uns, wdata, r, ee);
      sb_q.push_back('{rdata: r, err: ee, drive_cyc: cyc});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = {$urandom, $urandom};
    req_size = 2'($urandom); req_wdata = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (stall > 0) begin
      rsp_ready = 1'b0;
      if (rsp_valid) stall--;
    end else begin
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare each new response against the scoreboard head, then watch it stay stable.
  logic        pending = 1'b0;
  logic [63:0] held_rdata, last_rdata;
  logic        held_err, last_err;
  int          hold_run = 0;
  int          last_hold = 0;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      pending = 1'b0;
    end else if (rsp_valid) begin
      if (!pending) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 64'(sb_q.size()), 1);
        end else begin
          e = sb_q[0];
          chk("latency", 64'(cyc - e.drive_cyc), 64'(LAT));
          chk("rdata", rsp_rdata, e.rdata);
          chk("err", 64'(rsp_err), 64'(e.err));
        end
        hold_run   = 0;
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
      end else begin
        hold_run++;
        chk("hold_rdata", rsp_rdata, held_rdata);
        chk("hold_err", 64'(rsp_err), 64'(held_err));
        chk("hold_req_ready", 64'(req_ready), 0);
      end
      held_rdata = rsp_rdata;
      held_err   = rsp_err;
      if (rsp_ready) begin
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        pending   = 1'b0;
        last_hold = hold_run;
      end else begin
        pending = 1'b1;
      end
    end else begin
      pending = 1'b0;
    end
  end

  initial begin
    int n;
    logic [1:0]  sz;
    logic [63:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_req_ready", 64'(req_ready), 1);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", 64'(rsp_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int ad = 0; ad < DEPTH; ad += 8) issue(1'b1, 64'(ad), 2'd3, 1'b0, {$urandom, $urandom}, 1'b1);
    wait_idle();

    issue(1'b1, 64'h10, 2'd0, 1'b0, 64'h80, 1'b1);
    issue(1'b0, 64'h10, 2'd0, 1'b0, 64'h0, 1'b1);
    wait_idle();
    chk("lb_signed", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_signed_err", 64'(last_err), 0);
    issue(1'b0, 64'h10, 2'd0, 1'b1, 64'h0, 1'b1);
    wait_idle();
    chk("lbu", last_rdata, 64'h80);

    issue(1'b1, 64'h20, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 1'b1);
    issue(1'b0, 64'h24, 2'd2, 1'b0, 64'h0, 1'b1);
    wait_idle();
    chk("lw_after_sd", last_rdata, 64'h0000_0000_1122_3344);
    chk("mem_0x20", 64'(dut.mem[32'h20]), 64'h88);

    issue(1'b1, 64'h21, 2'd1, 1'b0, 64'hBEEF, 1'b1);
    wait_idle();
    chk("sh_misaligned_err", 64'(last_err), 1);
    chk("mem_0x21_kept", 64'(dut.mem[32'h21]), 64'h77);
    chk("mem_0x22_kept", 64'(dut.mem[32'h22]), 64'h66);
    issue(1'b0, 64'(DEPTH - 2), 2'd2, 1'b0, 64'h0, 1'b1);
    wait_idle();
    chk("lw_oob_err", 64'(last_err), 1);

    issue(1'b0, 64'h20, 2'd3, 1'b0, 64'h0, 1'b1);
    stall = 5;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_seen", 64'(rsp_valid), 1);
    @(negedge clk);
    #2;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h40; req_size = 2'd3; req_wdata = '1;
    @(negedge clk);
    #2;
    req_valid = 1'b0;
    wait_idle();
    chk("stall_hold_ge5", 64'(last_hold >= 5), 1);
    chk("stall_rdata", last_rdata, 64'h1122_3344_5566_7788);
    chk("ignored_store_mem", 64'(dut.mem[32'h40]), 64'(model_mem[32'h40]));
    issue(1'b0, 64'h40, 2'd3, 1'b0, 64'h0, 1'b1);
    wait_idle();

    issue(1'b1, 64'h30, 2'd3, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst_req_ready", 64'(req_ready), 1);
    chk("midrst_rsp_valid", 64'(rsp_valid), 0);
    chk("midrst_rsp_rdata", rsp_rdata, 0);
    chk("midrst_rsp_err", 64'(rsp_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_mem_0x30", 64'(dut.mem[32'h30]), 64'(model_mem[32'h30]));
    issue(1'b0, 64'h30, 2'd3, 1'b0, 64'h0, 1'b1);
    wait_idle();

    for (int k = 0; k < 300; k++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       a = {$urandom, $urandom};
        1:       a = 64'($urandom_range(0, DEPTH + 16));
        2, 3, 4: a = 64'($urandom_range(0, 63)) & ~((64'd1 << sz) - 1);
        default: a = 64'($urandom_range(0, DEPTH - 1)) & ~((64'd1 << sz) - 1);
      endcase
      issue(1'($urandom), a, sz, 1'($urandom), {$urandom, $urandom}, 1'b1);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
